// File: rtl/avr_cpu_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_control_pkg
// Brief    : Opcode match patterns, FSM state and instruction-kind encodings.
// Revision : 1.0
// ============================================================================
package avr_cpu_control_pkg;

    // Mask/value pairs: an opcode matches when (opcode & mask) == value.
    localparam logic [15:0] c_rjmp_mask   = 16'hF000;
    localparam logic [15:0] c_rjmp_val    = 16'hC000;
    localparam logic [15:0] c_rcall_mask  = 16'hF000;
    localparam logic [15:0] c_rcall_val   = 16'hD000;
    localparam logic [15:0] c_ret_mask    = 16'hFFFF;
    localparam logic [15:0] c_ret_val     = 16'h9508;
    localparam logic [15:0] c_brbx_mask   = 16'hF800;
    localparam logic [15:0] c_brbx_val    = 16'hF000;
    localparam logic [15:0] c_lpm0_mask   = 16'hFFFF;
    localparam logic [15:0] c_lpm0_val    = 16'h95C8;
    localparam logic [15:0] c_lpmz_mask   = 16'hFE0F;
    localparam logic [15:0] c_lpmz_val    = 16'h9004;
    localparam logic [15:0] c_lpmzp_mask  = 16'hFE0F;
    localparam logic [15:0] c_lpmzp_val   = 16'h9005;

    typedef enum logic [0:0] {
        ST_EXEC   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_JMP  = 2'd1,
        KIND_LPM  = 2'd2
    } kind_e;

    function automatic logic op_match(input logic [15:0] op,
                                      input logic [15:0] mask,
                                      input logic [15:0] val);
        return (op & mask) == val;
    endfunction

endpackage : avr_cpu_control_pkg
`default_nettype wire

// File: rtl/avr_cpu_control_if.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_control_if
// Brief    : Fetch/regfile-side bundle of the control stage.
// Revision : 1.0
// ============================================================================
interface avr_cpu_control_if #(
    parameter int PC_W   = 16,
    parameter int SREG_W = 8
);
    logic [15:0]       opcode;
    logic              cycle;
    logic [SREG_W-1:0] sreg;
    logic [15:0]       z_ptr;
    logic [7:0]        lpm_data;

    logic [PC_W-1:0]   pc_update;
    logic              hold;
    logic              read_stack;
    logic              write_stack;
    logic              lpm_read;
    logic [15:0]       lpm_addr;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [7:0]        rf_wdata;
    logic              z_inc;
    logic              illegal;

    modport master (
        input  opcode, cycle, sreg, z_ptr, lpm_data,
        output pc_update, hold, read_stack, write_stack, lpm_read, lpm_addr,
               rf_we, rf_waddr, rf_wdata, z_inc, illegal
    );

    modport slave (
        output opcode, cycle, sreg, z_ptr, lpm_data,
        input  pc_update, hold, read_stack, write_stack, lpm_read, lpm_addr,
               rf_we, rf_waddr, rf_wdata, z_inc, illegal
    );

endinterface : avr_cpu_control_if
`default_nettype wire

// File: rtl/avr_cpu_control_decode.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_control_decode
// Brief    : Combinational classifier for control-flow and LPM opcodes.
// Revision : 1.0
// ============================================================================
module avr_cpu_control_decode
    import avr_cpu_control_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [15:0]     opcode,
    output kind_e           kind,
    output logic [PC_W-1:0] offset,
    output logic [4:0]      rd,
    output logic            zplus,
    output logic            is_branch,
    output logic            is_call,
    output logic            is_ret,
    output logic            br_clr,
    output logic [2:0]      br_bit
);

    always_comb begin
        kind      = KIND_NONE;
        offset    = '0;
        rd        = '0;
        zplus     = 1'b0;
        is_branch = 1'b0;
        is_call   = 1'b0;
        is_ret    = 1'b0;
        br_clr    = opcode[10];
        br_bit    = opcode[2:0];

        if (op_match(opcode, c_rjmp_mask, c_rjmp_val)) begin
            kind   = KIND_JMP;
            offset = {{(PC_W-12){opcode[11]}}, opcode[11:0]};
        end else if (op_match(opcode, c_rcall_mask, c_rcall_val)) begin
            kind    = KIND_JMP;
            is_call = 1'b1;
            offset  = {{(PC_W-12){opcode[11]}}, opcode[11:0]};
        end else if (op_match(opcode, c_ret_mask, c_ret_val)) begin
            kind   = KIND_JMP;
            is_ret = 1'b1;
        end else if (op_match(opcode, c_brbx_mask, c_brbx_val)) begin
            // Branches are classified as jumps; whether they are taken is
            // resolved against SREG by the sequencer.
            kind      = KIND_JMP;
            is_branch = 1'b1;
            offset    = {{(PC_W-7){opcode[9]}}, opcode[9:3]};
        end else if (op_match(opcode, c_lpm0_mask, c_lpm0_val)) begin
            kind = KIND_LPM;
        end else if (op_match(opcode, c_lpmz_mask, c_lpmz_val)) begin
            kind = KIND_LPM;
            rd   = opcode[8:4];
        end else if (op_match(opcode, c_lpmzp_mask, c_lpmzp_val)) begin
            kind  = KIND_LPM;
            rd    = opcode[8:4];
            zplus = 1'b1;
        end
    end

endmodule : avr_cpu_control_decode
`default_nettype wire

// File: rtl/avr_cpu_control.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_control
// Brief    : Two-cycle sequencer for jumps/calls/returns/branches and LPM.
// Revision : 1.0
// ============================================================================
module avr_cpu_control
    import avr_cpu_control_pkg::*;
#(
    parameter int PC_W   = 16,
    parameter int SREG_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    avr_cpu_control_if.master  bus
);

    state_e          state_q, state_d;
    kind_e           kind_q,  kind_d;
    logic [4:0]      rd_q,    rd_d;
    logic            zplus_q, zplus_d;

    kind_e           w_dec_kind;
    logic [PC_W-1:0] w_dec_offset;
    logic [4:0]      w_dec_rd;
    logic            w_dec_zplus;
    logic            w_dec_is_branch;
    logic            w_dec_is_call;
    logic            w_dec_is_ret;
    logic            w_dec_br_clr;
    logic [2:0]      w_dec_br_bit;
    logic            w_taken;

    logic [PC_W-1:0] w_pc_update;
    logic            w_hold;
    logic            w_read_stack;
    logic            w_write_stack;
    logic            w_lpm_read;
    logic [15:0]     w_lpm_addr;
    logic            w_rf_we;
    logic [4:0]      w_rf_waddr;
    logic [7:0]      w_rf_wdata;
    logic            w_z_inc;
    logic            w_illegal;

    avr_cpu_control_decode #(
        .PC_W (PC_W)
    ) u_decode (
        .opcode    (bus.opcode),
        .kind      (w_dec_kind),
        .offset    (w_dec_offset),
        .rd        (w_dec_rd),
        .zplus     (w_dec_zplus),
        .is_branch (w_dec_is_branch),
        .is_call   (w_dec_is_call),
        .is_ret    (w_dec_is_ret),
        .br_clr    (w_dec_br_clr),
        .br_bit    (w_dec_br_bit)
    );

    // BRBS (bit10=0) is taken on a set flag, BRBC (bit10=1) on a clear one.
    assign w_taken = bus.sreg[w_dec_br_bit] == ~w_dec_br_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EXEC;
            kind_q  <= KIND_NONE;
            rd_q    <= '0;
            zplus_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            rd_q    <= rd_d;
            zplus_q <= zplus_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        kind_d        = KIND_NONE;
        rd_d          = rd_q;
        zplus_d       = zplus_q;
        w_pc_update   = '0;
        w_hold        = 1'b0;
        w_read_stack  = 1'b0;
        w_write_stack = 1'b0;
        w_lpm_read    = 1'b0;
        w_lpm_addr    = '0;
        w_rf_we       = 1'b0;
        w_rf_waddr    = '0;
        w_rf_wdata    = '0;
        w_z_inc       = 1'b0;
        w_illegal     = 1'b0;

        case (state_q)
            ST_EXEC: begin
                w_illegal = bus.cycle;
                case (w_dec_kind)
                    KIND_JMP: begin
                        if (!w_dec_is_branch || w_taken) begin
                            w_hold        = 1'b1;
                            w_pc_update   = w_dec_offset;
                            w_write_stack = w_dec_is_call;
                            w_read_stack  = w_dec_is_ret;
                            kind_d        = KIND_JMP;
                            state_d       = ST_SECOND;
                        end
                    end
                    KIND_LPM: begin
                        w_hold     = 1'b1;
                        w_lpm_read = 1'b1;
                        w_lpm_addr = bus.z_ptr;
                        rd_d       = w_dec_rd;
                        zplus_d    = w_dec_zplus;
                        kind_d     = KIND_LPM;
                        state_d    = ST_SECOND;
                    end
                    default: ;
                endcase
            end
            ST_SECOND: begin
                state_d = ST_EXEC;
                if (kind_q == KIND_LPM) begin
                    w_rf_we    = 1'b1;
                    w_rf_waddr = rd_q;
                    w_rf_wdata = bus.lpm_data;
                    w_z_inc    = zplus_q;
                end
            end
            default: state_d = ST_EXEC;
        endcase

        // Outputs are quiet while reset is held, including a reset that lands
        // in the middle of a two-cycle sequence (no stray write or Z update).
        if (!rst_n) begin
            w_pc_update   = '0;
            w_hold        = 1'b0;
            w_read_stack  = 1'b0;
            w_write_stack = 1'b0;
            w_lpm_read    = 1'b0;
            w_lpm_addr    = '0;
            w_rf_we       = 1'b0;
            w_rf_waddr    = '0;
            w_rf_wdata    = '0;
            w_z_inc       = 1'b0;
            w_illegal     = 1'b0;
        end
    end

    assign bus.pc_update   = w_pc_update;
    assign bus.hold        = w_hold;
    assign bus.read_stack  = w_read_stack;
    assign bus.write_stack = w_write_stack;
    assign bus.lpm_read    = w_lpm_read;
    assign bus.lpm_addr    = w_lpm_addr;
    assign bus.rf_we       = w_rf_we;
    assign bus.rf_waddr    = w_rf_waddr;
    assign bus.rf_wdata    = w_rf_wdata;
    assign bus.z_inc       = w_z_inc;
    assign bus.illegal     = w_illegal;

endmodule : avr_cpu_control
`default_nettype wire
